// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch / sequence controller.
// Fetches opcodes (and branch operands) from a variable-latency instruction
// memory, drives the PC increment/branch controls, hands datapath opcodes to
// the datapath and decodes JMP / JMPZ / HALT / NOP locally.
// Optional build macro SINGLE_STEP_EN: adds a `step` input and stops in
// HALTED after every instruction so each step pulse retires one instruction.
module fetch_sequencer #(
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               start,
  input  logic               halt_req,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               exec_done,
  input  logic               z_flag,
  output logic               imem_req,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_start,
  output logic               PCI,
  output logic               BRANCH,
  output logic [ADDR_W-1:0]  target,
  output logic               busy,
  output logic               halted,
  output logic               fetch_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_OPFETCH = 3'd4;
  localparam logic [2:0] S_UPD     = 3'd5;
  localparam logic [2:0] S_HALTED  = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  // Last wait cycle before a missing ack turns into a fetch error.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state, nxt;
  logic [7:0] tcnt;
  logic       taken;
  logic [1:0] opc;
  logic       is_halt;
  logic       stop_at_bnd;
  logic       resume;
  logic [2:0] bnd_state;

  assign opc     = ir[INSTR_W-1 -: 2];
  assign is_halt = (opc == 2'b11) && (&ir[INSTR_W-3:0]);

`ifdef SINGLE_STEP_EN
  // Stepping stops at every instruction boundary; halt_req is subsumed.
  assign stop_at_bnd = 1'b1 | halt_req;
  assign resume      = start | step;
`else
  assign stop_at_bnd = halt_req;
  assign resume      = start;
`endif

  assign bnd_state = stop_at_bnd ? S_HALTED : S_FETCH;

  // Next-state decode.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack)             nxt = S_DECODE;
        else if (tcnt == TO_LAST) nxt = S_ERROR;
      end
      S_DECODE: begin
        case (opc)
          2'b00:        nxt = S_EXEC;
          2'b01, 2'b10: nxt = S_OPFETCH;
          default:      nxt = is_halt ? S_HALTED : bnd_state;
        endcase
      end
      S_EXEC:    if (exec_done) nxt = bnd_state;
      S_OPFETCH: begin
        if (imem_ack)             nxt = S_UPD;
        else if (tcnt == TO_LAST) nxt = S_ERROR;
      end
      S_UPD:     nxt = bnd_state;
      S_HALTED:  if (resume) nxt = S_FETCH;
      S_ERROR:   if (start) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // State, instruction register, branch operand and the exec_start pulse.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      ir         <= '0;
      target     <= '0;
      taken      <= 1'b0;
      exec_start <= 1'b0;
    end else begin
      state      <= nxt;
      exec_start <= (state == S_DECODE) && (opc == 2'b00);
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (state == S_OPFETCH && imem_ack) begin
        target <= imem_rdata[ADDR_W-1:0];
        taken  <= (opc == 2'b01) || z_flag;
      end
    end
  end

  // Ack timeout counter: restarts on every new memory request phase.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)
      tcnt <= '0;
    else if ((nxt == S_FETCH || nxt == S_OPFETCH) && nxt != state)
      tcnt <= '0;
    else if (state == S_ERROR && start)
      tcnt <= '0;
    else if (imem_req && !imem_ack)
      tcnt <= tcnt + 8'd1;
  end

  // Moore outputs; PCI and BRANCH are mutually exclusive by construction.
  always_comb begin
    imem_req  = (state == S_FETCH) || (state == S_OPFETCH);
    PCI       = (state == S_DECODE) || (state == S_UPD && !taken);
    BRANCH    = (state == S_UPD) && taken;
    busy      = !(state == S_IDLE || state == S_HALTED || state == S_ERROR);
    halted    = (state == S_HALTED);
    fetch_err = (state == S_ERROR);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a PC register, a variable-latency instruction
// memory, a datapath responder and an instruction-level reference model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       RST, start, halt_req, imem_ack, exec_done, z_flag;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif
  logic [7:0] imem_rdata;
  logic       imem_req, exec_start, PCI, BRANCH, busy, halted, fetch_err;
  logic [7:0] ir, target;

  fetch_sequencer dut (
    .clk(clk), .RST(RST), .start(start), .halt_req(halt_req),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .exec_done(exec_done),
    .z_flag(z_flag), .imem_req(imem_req), .ir(ir), .exec_start(exec_start),
    .PCI(PCI), .BRANCH(BRANCH), .target(target), .busy(busy),
    .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Program counter the sequencer controls.
  logic [7:0] pc;
  always_ff @(posedge clk or negedge RST)
    if (!RST)        pc <= 8'h00;
    else if (BRANCH) pc <= target;
    else if (PCI)    pc <= pc + 8'd1;

  // Memory / datapath responder state and observation logs.
  logic [7:0] mem [256];
  int lat_mode = 0, exec_mode = 0, cur_lat = 0, wcnt = 0, dcnt = 0;
  bit pend = 0, auto_step = 1;
  int n_pci = 0, n_br = 0, n_both = 0;
  logic [7:0] got_addr[$], got_exec[$], br_tgt[$], exp_addr[$], exp_exec[$];
  bit m_halt;
  logic [7:0] m_pc;

  function automatic int pick_lat();
    return (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
  endfunction

  // Responds at the falling edge; responses are seen by the next rising edge.
  always @(negedge clk) begin
    if (!RST) begin
      imem_ack = 0; exec_done = 0; wcnt = 0; pend = 0; cur_lat = pick_lat();
    end else begin
      exec_done = 0;
      if (exec_start) begin
        got_exec.push_back(ir);
        pend = 1;
        dcnt = (exec_mode < 0) ? int'($urandom_range(0, 3)) : exec_mode;
      end
      if (pend) begin
        if (dcnt == 0) begin exec_done = 1; pend = 0; end
        else dcnt--;
      end
      imem_ack = 0;
      if (imem_req) begin
        if (wcnt >= cur_lat) begin
          imem_ack = 1; imem_rdata = mem[pc]; got_addr.push_back(pc);
          wcnt = 0; cur_lat = pick_lat();
        end else wcnt++;
      end
      if (PCI) n_pci++;
      if (BRANCH) begin n_br++; br_tgt.push_back(target); end
      if (PCI && BRANCH) n_both++;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic set_lat(input int v);
    lat_mode = v; cur_lat = pick_lat(); wcnt = 0;
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    RST = 0; start = 0; halt_req = 0; z_flag = 0;
`ifdef SINGLE_STEP_EN
    step = 0;
`endif
    tick(); tick();
    got_addr.delete(); got_exec.delete(); br_tgt.delete();
    n_pci = 0; n_br = 0; n_both = 0;
    RST = 1; set_lat(0); exec_mode = 0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  // Runs until HALTED or ERROR; a step-mode stop on a non-HALT opcode is
  // resumed automatically when auto_step is set.
  task automatic wait_halted(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
`ifdef SINGLE_STEP_EN
      if (halted && auto_step && ir != 8'hFF) begin step = 1; tick(); step = 0; continue; end
`endif
      if (halted || fetch_err) break;
      tick();
    end
    checks++;
    if (i >= budget) begin
      failures++; $display("FAIL %s_timeout got=busy exp=halted within %0d cycles", name, budget);
    end
  endtask

  function automatic bit qeq(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  // Instruction-level interpreter: which bytes get fetched, which opcodes
  // reach the datapath, and where the PC ends up.
  task automatic model(input logic z);
    logic [7:0] p, op;
    exp_addr.delete(); exp_exec.delete(); m_halt = 0; p = 8'h00;
    while (exp_addr.size() < 256 && !m_halt) begin
      op = mem[p]; exp_addr.push_back(p); p = p + 8'd1;
      case (op[7:6])
        2'b00: exp_exec.push_back(op);
        2'b01, 2'b10: begin
          exp_addr.push_back(p);
          if (op[7:6] == 2'b01 || z) p = mem[p]; else p = p + 8'd1;
        end
        default: if (op[5:0] == 6'h3F) m_halt = 1;
      endcase
    end
    m_pc = p;
  endtask

  task automatic test_reset();
    RST = 1; start = 0; halt_req = 0; z_flag = 0;
`ifdef SINGLE_STEP_EN
    step = 0;
`endif
    #2 RST = 0; #1;
    checks++;
    if ({imem_req, exec_start, PCI, BRANCH, busy, halted, fetch_err, ir, target} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0",
        {imem_req, exec_start, PCI, BRANCH, busy, halted, fetch_err, ir, target});
    end
    tick(); RST = 1; set_lat(0); tick(); tick();
    checks++;
    if ({busy, imem_req, halted} !== 3'b000) begin
      failures++; $display("FAIL idle_hold got=%b exp=000", {busy, imem_req, halted});
    end
  endtask

  task automatic test_fetch_exec();
    int n = 0, bad = 0;
    do_reset(); fill_mem(8'hFF); mem[0] = 8'h05;
    set_lat(2); exec_mode = 4;
    pulse_start();
    for (int i = 0; i < 20 && !PCI; i++) begin if (imem_req) n++; tick(); end
    checks++;
    if (n != 3) begin failures++; $display("FAIL fetch_req_cycles got=%0d exp=3", n); end
    checks++;
    if ({PCI, imem_req, ir} !== {2'b10, 8'h05}) begin
      failures++; $display("FAIL decode got=%b/%b/%0h exp=1/0/05", PCI, imem_req, ir);
    end
    tick();
    checks++;
    if ({exec_start, busy} !== 2'b11) begin
      failures++; $display("FAIL exec_start got=%b exp=11", {exec_start, busy});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (exec_start || imem_req || PCI || !busy) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL exec_wait got=%0d bad cycles exp=0", bad); end
    tick();
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL after_exec_fetch got=%b exp=1", imem_req); end
    wait_halted(40, "fetch_exec");
    exp_addr = '{8'h00, 8'h01}; exp_exec = '{8'h05};
    checks++;
    if (!qeq(got_addr, exp_addr) || !qeq(got_exec, exp_exec) || pc !== 8'h02) begin
      failures++; $display("FAIL fetch_exec_trace got=%0d addrs/%0d execs pc=%0h exp=2/1 pc=02",
        got_addr.size(), got_exec.size(), pc);
    end
  endtask

  task automatic test_jmp();
    do_reset(); fill_mem(8'hC0); mem[0] = 8'h40; mem[1] = 8'h20; mem[8'h20] = 8'hFF;
    set_lat(-1);
    pulse_start();
    wait_halted(60, "jmp");
    exp_addr = '{8'h00, 8'h01, 8'h20};
    checks++;
    if (n_br != 1 || br_tgt.size() != 1 || n_both != 0) begin
      failures++; $display("FAIL jmp_branch got=%0d branches %0d overlaps exp=1/0", n_br, n_both);
    end else begin
      checks++;
      if (br_tgt[0] !== 8'h20) begin failures++; $display("FAIL jmp_target got=%0h exp=20", br_tgt[0]); end
    end
    checks++;
    if (n_pci != 2) begin failures++; $display("FAIL jmp_pci got=%0d exp=2", n_pci); end
    checks++;
    if (!qeq(got_addr, exp_addr) || pc !== 8'h21) begin
      failures++; $display("FAIL jmp_trace got=%0d addrs pc=%0h exp=3 pc=21", got_addr.size(), pc);
    end
  endtask

  task automatic test_jmpz();
    for (int z = 0; z < 2; z++) begin
      do_reset(); fill_mem(8'hC0);
      mem[0] = 8'h80; mem[1] = 8'h33; mem[2] = 8'hFF; mem[8'h33] = 8'hFF;
      set_lat(-1); z_flag = z[0];
      pulse_start();
      wait_halted(60, "jmpz");
      if (z == 0) exp_addr = '{8'h00, 8'h01, 8'h02};
      else        exp_addr = '{8'h00, 8'h01, 8'h33};
      checks++;
      if (n_br != z || n_pci != 3 - z || n_both != 0) begin
        failures++; $display("FAIL jmpz_ctrl z=%0d got=br%0d/pci%0d exp=br%0d/pci%0d",
          z, n_br, n_pci, z, 3 - z);
      end
      checks++;
      if (!qeq(got_addr, exp_addr) || pc !== (z ? 8'h34 : 8'h03) || target !== 8'h33) begin
        failures++; $display("FAIL jmpz_trace z=%0d got=pc%0h tgt%0h exp=pc%0h tgt33",
          z, pc, target, z ? 8'h34 : 8'h03);
      end
    end
  endtask

  task automatic test_halt();
    do_reset(); fill_mem(8'hC0); mem[0] = 8'hFF; mem[1] = 8'h05; mem[2] = 8'hFF;
    set_lat(-1); exec_mode = -1;
    pulse_start();
    wait_halted(30, "halt");
    checks++;
    if ({halted, busy, fetch_err} !== 3'b100 || pc !== 8'h01) begin
      failures++; $display("FAIL halt_state got=%b pc=%0h exp=100 pc=01", {halted, busy, fetch_err}, pc);
    end
    pulse_start();
    wait_halted(40, "resume");
    exp_addr = '{8'h00, 8'h01, 8'h02}; exp_exec = '{8'h05};
    checks++;
    if (!qeq(got_addr, exp_addr) || !qeq(got_exec, exp_exec) || pc !== 8'h03) begin
      failures++; $display("FAIL resume_trace got=%0d addrs pc=%0h exp=3 pc=03", got_addr.size(), pc);
    end
  endtask

  task automatic test_halt_req();
    do_reset(); fill_mem(8'hC0); set_lat(1); auto_step = 0;
    halt_req = 1;
    pulse_start();
    wait_halted(20, "halt_req");
    halt_req = 0; auto_step = 1;
    checks++;
    if (pc !== 8'h01 || n_pci != 1 || got_addr.size() != 1 || !halted) begin
      failures++; $display("FAIL halt_req_stop got=pc%0h pci%0d exp=pc01 pci1", pc, n_pci);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset(); fill_mem(8'hFF); set_lat(1000);
    pulse_start();
    for (int i = 0; i < 40 && !fetch_err; i++) begin if (imem_req) n++; tick(); end
    checks++;
    if (n != 15) begin failures++; $display("FAIL timeout_cycles got=%0d exp=15", n); end
    checks++;
    if ({fetch_err, imem_req, busy, halted} !== 4'b1000) begin
      failures++; $display("FAIL error_state got=%b exp=1000", {fetch_err, imem_req, busy, halted});
    end
    pulse_start();
    checks++;
    if ({fetch_err, busy, halted} !== 3'b000) begin
      failures++; $display("FAIL error_to_idle got=%b exp=000", {fetch_err, busy, halted});
    end
    set_lat(14); n = 0;
    pulse_start();
    for (int i = 0; i < 40 && !halted && !fetch_err; i++) begin if (imem_req) n++; tick(); end
    checks++;
    if (n != 15 || !halted || fetch_err) begin
      failures++; $display("FAIL late_ack_wins got=%0d cycles err=%b exp=15 err=0", n, fetch_err);
    end
  endtask

  task automatic test_reset_mid_exec();
    int i;
    do_reset(); fill_mem(8'hFF); mem[0] = 8'h05; exec_mode = 1000;
    pulse_start();
    for (i = 0; i < 20 && !exec_start; i++) tick();
    tick(); tick();
    checks++;
    if (!busy) begin failures++; $display("FAIL mid_exec_busy got=%b exp=1", busy); end
    RST = 0; #1;
    checks++;
    if ({imem_req, exec_start, PCI, BRANCH, busy, halted, fetch_err, ir, target} !== '0) begin
      failures++; $display("FAIL reset_abort got=%0h exp=0",
        {imem_req, exec_start, PCI, BRANCH, busy, halted, fetch_err, ir, target});
    end
    tick(); RST = 1; set_lat(0); tick(); tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL post_abort_idle got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int bad_a = 0, bad_e = 0, i;
      logic z;
      do_reset();
      for (int k = 0; k < 256; k++) mem[k] = ($urandom_range(0, 11) == 0) ? 8'hFF : 8'($urandom);
      z = 1'($urandom); z_flag = z;
      set_lat(-1); exec_mode = -1;
      model(z);
      pulse_start();
      for (i = 0; i < 300 && !halted; i++) begin
`ifdef SINGLE_STEP_EN
        if (halted) break;
`endif
        tick();
`ifdef SINGLE_STEP_EN
        if (halted && ir != 8'hFF) begin step = 1; tick(); step = 0; end
`endif
      end
      foreach (got_addr[k]) if (k >= exp_addr.size() || got_addr[k] !== exp_addr[k]) bad_a++;
      foreach (got_exec[k]) if (k >= exp_exec.size() || got_exec[k] !== exp_exec[k]) bad_e++;
      checks++;
      if (bad_a != 0 || got_addr.size() == 0) begin
        failures++; $display("FAIL rand_addr run=%0d got=%0d bad of %0d exp=0 bad", r, bad_a, got_addr.size());
      end
      checks++;
      if (bad_e != 0 || n_both != 0) begin
        failures++; $display("FAIL rand_exec run=%0d got=%0d bad %0d overlap exp=0/0", r, bad_e, n_both);
      end
      if (halted) begin
        checks++;
        if (!m_halt || got_addr.size() != exp_addr.size() || got_exec.size() != exp_exec.size() || pc !== m_pc) begin
          failures++; $display("FAIL rand_halt run=%0d got=pc%0h n%0d exp=pc%0h n%0d",
            r, pc, got_addr.size(), m_pc, exp_addr.size());
        end
      end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    int n0;
    do_reset(); fill_mem(8'hC0); set_lat(-1); auto_step = 0;
    pulse_start();
    wait_halted(20, "step0");
    checks++;
    if (pc !== 8'h01 || n_pci != 1) begin
      failures++; $display("FAIL step_first got=pc%0h pci%0d exp=pc01 pci1", pc, n_pci);
    end
    for (int k = 0; k < 2; k++) begin
      n0 = n_pci;
      step = 1; tick(); step = 0;
      wait_halted(20, "step");
      checks++;
      if (n_pci - n0 != 1 || pc !== 8'(k + 2)) begin
        failures++; $display("FAIL step_one got=pci%0d pc%0h exp=pci1 pc%0h", n_pci - n0, pc, k + 2);
      end
    end
    auto_step = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_exec();
    test_jmp();
    test_jmpz();
    test_halt();
    test_halt_req();
    test_timeout();
    test_reset_mid_exec();
    test_random();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
